// File: rtl/gray_pkg.sv
// Shared types and reference helpers for the gray-code conversion arbiter.
package gray_pkg;

  localparam int GRAY_W = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Reference conversion for any width up to 32 bits; MSB passes through, each lower bit folds in the one above.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int width);
    logic [31:0] bin;
    bin = 32'd0;
    bin[width-1] = gray[width-1];
    for (int k = width - 2; k >= 0; k--) begin
      bin[k] = bin[k+1] ^ gray[k];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational gray-to-binary converter, one instance shared by all requesters.
module gray_to_binary
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] binary
);

  // Each binary bit is the parity of the gray bits at and above it.
  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    assign binary[k] = ^gray[WIDTH-1:k];
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter feeding one shared gray-to-binary converter into a single output register.
// Optional build macro GAC_STATS_EN adds a saturating stat_count of completed output handshakes.
module gray_conv_arbiter
  import gray_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = GRAY_W,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_gray,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_binary,
`ifdef GAC_STATS_EN
  output logic [ID_W-1:0]          out_id,
  output logic [15:0]              stat_count
`else
  output logic [ID_W-1:0]          out_id
`endif
);

  localparam int IDX_W = ID_W + 1;

  state_e             state_r;
  logic               out_valid_r;
  logic [WIDTH-1:0]   out_binary_r;
  logic [ID_W-1:0]    out_id_r;
  logic [ID_W-1:0]    rr_ptr_r;

  logic               can_accept_s;
  logic               found_s;
  logic [ID_W-1:0]    grant_idx_s;
  logic [IDX_W-1:0]   idx_s;
  logic [NUM_REQ-1:0] grant_s;
  logic               xfer_s;
  logic [WIDTH-1:0]   winner_gray_s;
  logic [WIDTH-1:0]   winner_bin_s;
  logic [ID_W-1:0]    next_ptr_s;

  assign can_accept_s = (state_r == EMPTY) || (out_ready && out_valid_r);

  // Round-robin search: first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = {ID_W{1'b0}};
    idx_s       = {IDX_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = {1'b0, rr_ptr_r} + IDX_W'(k);
      if (idx_s >= IDX_W'(NUM_REQ)) begin
        idx_s = idx_s - IDX_W'(NUM_REQ);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req_valid[idx_s[ID_W-1:0]]) begin
        found_s     = 1'b1;
        grant_idx_s = idx_s[ID_W-1:0];
      end else begin
        found_s     = found_s;
        grant_idx_s = grant_idx_s;
      end
    end
  end

  // One-hot grant, suppressed while resetting or when the output stage cannot take data.
  always_comb begin
    grant_s = {NUM_REQ{1'b0}};
    if (!rst && can_accept_s && found_s) begin
      grant_s[grant_idx_s] = 1'b1;
    end else begin
      grant_s = {NUM_REQ{1'b0}};
    end
  end

  assign xfer_s = |(grant_s & req_valid);

  // Pointer advances past the winner so it becomes lowest priority next time.
  always_comb begin
    next_ptr_s = {ID_W{1'b0}};
    if (grant_idx_s == ID_W'(NUM_REQ - 1)) begin
      next_ptr_s = {ID_W{1'b0}};
    end else begin
      next_ptr_s = grant_idx_s + {{(ID_W-1){1'b0}}, 1'b1};
    end
  end

  assign winner_gray_s = req_gray[grant_idx_s*WIDTH +: WIDTH];

  gray_to_binary #(
    .WIDTH (WIDTH)
  ) u_g2b (
    .gray   (winner_gray_s),
    .binary (winner_bin_s)
  );

  // Output-stage FSM: a transfer always (re)loads FULL; a bare drain empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= EMPTY;
      out_valid_r  <= 1'b0;
      out_binary_r <= {WIDTH{1'b0}};
      out_id_r     <= {ID_W{1'b0}};
      rr_ptr_r     <= {ID_W{1'b0}};
    end else begin
      case (state_r)
        EMPTY: begin
          if (xfer_s) begin
            state_r      <= FULL;
            out_valid_r  <= 1'b1;
            out_binary_r <= winner_bin_s;
            out_id_r     <= grant_idx_s;
            rr_ptr_r     <= next_ptr_s;
          end else begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
          end
        end
        FULL: begin
          if (xfer_s) begin
            state_r      <= FULL;
            out_valid_r  <= 1'b1;
            out_binary_r <= winner_bin_s;
            out_id_r     <= grant_idx_s;
            rr_ptr_r     <= next_ptr_s;
          end else if (out_ready) begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
          end else begin
            state_r     <= FULL;
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= EMPTY;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef GAC_STATS_EN
  logic [15:0] stat_count_r;

  // Saturating count of handshakes seen on the output side.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_count_r <= 16'd0;
    end else if (out_valid_r && out_ready && (stat_count_r != 16'hFFFF)) begin
      stat_count_r <= stat_count_r + 16'd1;
    end else begin
      stat_count_r <= stat_count_r;
    end
  end

  assign stat_count = stat_count_r;
`endif

  assign req_ready  = grant_s;
  assign out_valid  = out_valid_r;
  assign out_binary = out_binary_r;
  assign out_id     = out_id_r;

endmodule
